sec_frame_config_mem: RTL
=========================

Name: sec_frame_config_mem

Overview:
- Clocked, parametrised successor to the per-tile latch-based frame configuration memory.
- Frames arrive over a valid/ready handshake with an address and a parity bit, and are written into a shadow frame array.
- The shadow array is copied atomically, frame by frame, to the active configuration bits on a commit request.
- Provides frame readback of the shadow array and a sticky parity-error flag; a commit is refused while that flag is set.

Parameters:
- FrameBitsPerRow, 32, width of one frame word.
- NoFrames, 2, number of frames stored by this tile (at least 1).
- NoConfigBits, 47, configuration bits exported; must satisfy NoConfigBits <= NoFrames*FrameBitsPerRow.
- AddrW, $clog2(NoFrames) with minimum 1, width of the frame address fields.

Ports:
- CLK  in  1  system clock; all state updates on its rising edge.
- RST  in  1  synchronous, active-high reset.
- FrameData  in  FrameBitsPerRow  frame word to write.
- FrameAddr  in  AddrW  target frame index.
- FrameParity  in  1  even-parity bit over FrameData.
- FrameValid  in  1  write request.
- FrameReady  out  1  write accept.
- Commit  in  1  single-cycle request to copy shadow to active.
- ErrClear  in  1  clears ParityErr and AddrErr.
- RdAddr  in  AddrW  readback frame index.
- RdReq  in  1  readback request.
- RdData  out  FrameBitsPerRow  readback word.
- RdValid  out  1  RdData qualifier.
- Busy  out  1  commit sequence in progress.
- ParityErr  out  1  sticky parity-error flag.
- AddrErr  out  1  sticky flag for FrameAddr >= NoFrames.
- CommitDone  out  1  one-cycle pulse at the end of a commit.
- ConfigBits  out  NoConfigBits  active configuration.
- ConfigBits_N  out  NoConfigBits  bitwise complement of ConfigBits.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - Shadow and active arrays cleared to 0, so ConfigBits=0 and ConfigBits_N=all ones.
  - FrameReady=0 in the reset cycle; RdValid=0, Busy=0, ParityErr=0, AddrErr=0, CommitDone=0.
  - FSM returns to IDLE.
  - Reset during a commit aborts it; the active array is fully cleared, never left partially copied.
- FSM states: IDLE and COMMIT.
- IDLE:
  - FrameReady=1.
  - A write occurs when FrameValid && FrameReady.
  - If XOR(FrameData)^FrameParity==0 and FrameAddr<NoFrames, the shadow frame at FrameAddr is written on that edge.
  - A parity mismatch drops the write and sets ParityErr. An address out of range drops the write and sets AddrErr.
- Commit in IDLE:
  - If ParityErr==0 and AddrErr==0, go to COMMIT with counter=0 and assert Busy.
  - Otherwise the commit is ignored.
  - Commit and FrameValid in the same cycle: the write is applied first, and the commit then takes effect (the copy includes that frame). A write that sets an error flag in that cycle blocks the commit.
- COMMIT:
  - FrameReady=0 and Busy=1.
  - Each cycle copies shadow[counter] to active[counter], then increments counter.
  - After the copy of frame NoFrames-1: pulse CommitDone for 1 cycle, return to IDLE, Busy=0.
  - Total commit length is NoFrames cycles.
  - Commit pulses received in COMMIT are ignored.
- Bit mapping:
  - Frame f, FrameData bit b drives ConfigBits[NoConfigBits-1 - (f*FrameBitsPerRow + (FrameBitsPerRow-1-b))].
  - Indices below 0 are unused, and the corresponding shadow bits read back as written.
  - With defaults: frame0 bit31 maps to ConfigBits[46], frame0 bit0 to [15], frame1 bit31 to [14], frame1 bit17 to [0]. Frame1 bits 16..0 are stored but not exported.
- ConfigBits and ConfigBits_N are registered outputs of the active array; ConfigBits_N is always the exact complement.
- Readback:
  - RdReq is accepted in any state; RdValid=1 and RdData=shadow[RdAddr] one cycle later.
  - A write to the same address in the same cycle returns the old value.
  - RdAddr >= NoFrames returns 0 with RdValid=1.
  - RdData holds its value when RdValid=0.
- ErrClear clears both error flags next cycle. If an error event occurs in the same cycle, set wins.

Decomposition:
- Shared package sec_cfg_pkg holds:
  - FSM state enum (IDLE, COMMIT);
  - the function mapping (frame, bit) to a config index;
  - the parity function.
- Sub-module sec_frame_array: NoFrames x FrameBitsPerRow register array with one write port and one registered read port. It is used twice, for the shadow and active arrays.

Test Plan:
- Reset then write frame0=0xFFFF_FFFF with parity 0, commit -> after 2 cycles CommitDone=1, ConfigBits[46:15] all 1, [14:0]=0, ConfigBits_N=~ConfigBits.
- Write frame1=0x8002_0000 with parity 0, commit -> ConfigBits[14]=1, ConfigBits[0]=1, others in [14:0]=0; ConfigBits unchanged until the CommitDone cycle.
- Write frame0=0x1 with parity 0 (bad) -> ParityErr=1, shadow unchanged; a subsequent commit is ignored (Busy stays 0); ErrClear then commit -> CommitDone pulses.
- Write during COMMIT -> FrameReady=0, write held by the source; accepted in the first IDLE cycle, and not visible in ConfigBits until the next commit.
- FrameAddr=3 (out of range, AddrW=1 wraps to 1 for NoFrames=2; use NoFrames=3 with AddrW=2) -> AddrErr=1, no frame modified; RdReq RdAddr=3 -> RdData=0, RdValid=1.
- Assert RST in the middle of a commit (cycle 1 of 2) -> next cycle ConfigBits=0, Busy=0, CommitDone never pulses, readback of frame0 returns 0.

Source files
------------

// File: rtl/sec_cfg_pkg.sv
// Shared types and helpers for the tile frame configuration memory:
// commit FSM states, frame-bit to config-bit mapping and frame parity.
package sec_cfg_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        COMMIT = 1'b1
    } commitState_t;

    // Widest frame word the parity helper accepts; narrower words are zero-extended.
    localparam int MaxFrameBits = 1024;

    // XOR of all data bits; a frame is well-formed when this equals its parity bit.
    function automatic logic frameParity(input logic [MaxFrameBits-1:0] data);
        return ^data;
    endfunction

    // Frame f, bit b lands on ConfigBits[result]; negative results are not exported.
    function automatic int configIndex(
        input int frame,
        input int bitIdx,
        input int frameBits,
        input int noConfigBits
    );
        return noConfigBits - 1 - (frame * frameBits + (frameBits - 1 - bitIdx));
    endfunction

endpackage

// File: rtl/sec_frame_array.sv
// NoFrames x FrameBitsPerRow register array: one write port, one registered read port,
// and the whole array exposed flat (frame f at bits [f*FrameBitsPerRow +: FrameBitsPerRow]).
module sec_frame_array #(
    parameter int NoFrames        = 2,
    parameter int FrameBitsPerRow = 32,
    parameter int AddrW           = 1
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic                                WrEn,
    input  logic [AddrW-1:0]                    WrAddr,
    input  logic [FrameBitsPerRow-1:0]          WrData,
    input  logic                                RdEn,
    input  logic [AddrW-1:0]                    RdAddr,
    output logic [FrameBitsPerRow-1:0]          RdData,
    output logic                                RdValid,
    output logic [NoFrames*FrameBitsPerRow-1:0] Frames
);

    logic [FrameBitsPerRow-1:0] mem [NoFrames];

    logic wrInRange;
    logic rdInRange;

    assign wrInRange = int'(WrAddr) < NoFrames;
    assign rdInRange = int'(RdAddr) < NoFrames;

    // Read samples the pre-write contents, so a same-cycle write returns the old word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int f = 0; f < NoFrames; f++) begin
                mem[f] <= '0;
            end
            RdData  <= '0;
            RdValid <= 1'b0;
        end else begin
            if (WrEn && wrInRange) begin
                mem[WrAddr] <= WrData;
            end
            RdValid <= RdEn;
            if (RdEn) begin
                RdData <= rdInRange ? mem[RdAddr] : '0;
            end
        end
    end

    for (genvar f = 0; f < NoFrames; f++) begin : gFlat
        assign Frames[f*FrameBitsPerRow +: FrameBitsPerRow] = mem[f];
    end

endmodule

// File: rtl/sec_frame_config_mem.sv
// Frame configuration memory: parity-checked frame writes into a shadow array,
// frame-by-frame commit into the active array that drives ConfigBits, and shadow readback.
module sec_frame_config_mem
    import sec_cfg_pkg::*;
#(
    parameter int FrameBitsPerRow = 32,
    parameter int NoFrames        = 2,
    parameter int NoConfigBits    = 47,
    parameter int AddrW           = (NoFrames > 1) ? $clog2(NoFrames) : 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    input  logic [AddrW-1:0]           FrameAddr,
    input  logic                       FrameParity,
    input  logic                       FrameValid,
    output logic                       FrameReady,
    input  logic                       Commit,
    input  logic                       ErrClear,
    input  logic [AddrW-1:0]           RdAddr,
    input  logic                       RdReq,
    output logic [FrameBitsPerRow-1:0] RdData,
    output logic                       RdValid,
    output logic                       Busy,
    output logic                       ParityErr,
    output logic                       AddrErr,
    output logic                       CommitDone,
    output logic [NoConfigBits-1:0]    ConfigBits,
    output logic [NoConfigBits-1:0]    ConfigBits_N
);

    localparam int TotalBits = NoFrames * FrameBitsPerRow;

    commitState_t state;
    commitState_t stateNext;
    logic [AddrW-1:0] commitCnt;
    logic [AddrW-1:0] commitCntNext;
    logic commitDoneNext;

    logic wrFire;
    logic wrParityBad;
    logic wrAddrBad;
    logic wrEn;
    logic wrErr;
    logic errBlocked;

    logic [TotalBits-1:0]       shadowFrames;
    logic [TotalBits-1:0]       activeFrames;
    logic [FrameBitsPerRow-1:0] copyData;
    logic                       copyEn;

    logic [FrameBitsPerRow-1:0] unusedActRdData;
    logic                       unusedActRdValid;
    logic                       unusedActFrames;

    assign FrameReady  = (state == IDLE) && !RST;
    assign Busy        = (state == COMMIT);

    assign wrFire      = FrameValid && FrameReady;
    assign wrParityBad = frameParity(MaxFrameBits'(FrameData)) != FrameParity;
    assign wrAddrBad   = int'(FrameAddr) >= NoFrames;
    assign wrEn        = wrFire && !wrParityBad && !wrAddrBad;
    assign wrErr       = wrFire && (wrParityBad || wrAddrBad);

    // A write that raises an error this cycle blocks a simultaneous commit.
    assign errBlocked  = ParityErr || AddrErr || wrErr;

    assign copyEn      = (state == COMMIT);
    assign copyData    = shadowFrames[int'(commitCnt)*FrameBitsPerRow +: FrameBitsPerRow];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            commitCnt  <= '0;
            CommitDone <= 1'b0;
            ParityErr  <= 1'b0;
            AddrErr    <= 1'b0;
        end else begin
            state      <= stateNext;
            commitCnt  <= commitCntNext;
            CommitDone <= commitDoneNext;
            // New error events win over a same-cycle clear.
            ParityErr  <= (ParityErr && !ErrClear) || (wrFire && wrParityBad);
            AddrErr    <= (AddrErr && !ErrClear) || (wrFire && wrAddrBad);
        end
    end

    always_comb begin
        stateNext      = state;
        commitCntNext  = commitCnt;
        commitDoneNext = 1'b0;
        case (state)
            IDLE: begin
                if (Commit && !errBlocked) begin
                    stateNext     = COMMIT;
                    commitCntNext = '0;
                end
            end
            COMMIT: begin
                if (int'(commitCnt) == NoFrames - 1) begin
                    stateNext      = IDLE;
                    commitCntNext  = '0;
                    commitDoneNext = 1'b1;
                end else begin
                    commitCntNext = commitCnt + 1'b1;
                end
            end
            default: begin
                stateNext     = IDLE;
                commitCntNext = '0;
            end
        endcase
    end

    sec_frame_array #(
        .NoFrames       (NoFrames),
        .FrameBitsPerRow(FrameBitsPerRow),
        .AddrW          (AddrW)
    ) uShadow (
        .CLK    (CLK),
        .RST    (RST),
        .WrEn   (wrEn),
        .WrAddr (FrameAddr),
        .WrData (FrameData),
        .RdEn   (RdReq),
        .RdAddr (RdAddr),
        .RdData (RdData),
        .RdValid(RdValid),
        .Frames (shadowFrames)
    );

    sec_frame_array #(
        .NoFrames       (NoFrames),
        .FrameBitsPerRow(FrameBitsPerRow),
        .AddrW          (AddrW)
    ) uActive (
        .CLK    (CLK),
        .RST    (RST),
        .WrEn   (copyEn),
        .WrAddr (commitCnt),
        .WrData (copyData),
        .RdEn   (1'b0),
        .RdAddr ({AddrW{1'b0}}),
        .RdData (unusedActRdData),
        .RdValid(unusedActRdValid),
        .Frames (activeFrames)
    );

    // Trailing frame bits beyond NoConfigBits are stored but never exported.
    assign unusedActFrames = ^activeFrames;

    for (genvar f = 0; f < NoFrames; f++) begin : gMapFrame
        for (genvar b = 0; b < FrameBitsPerRow; b++) begin : gMapBit
            localparam int Idx = configIndex(f, b, FrameBitsPerRow, NoConfigBits);
            if (Idx >= 0) begin : gExport
                assign ConfigBits[Idx] = activeFrames[f*FrameBitsPerRow + b];
            end
        end
    end

    assign ConfigBits_N = ~ConfigBits;

endmodule
